dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS-lite core. It services the core's MEM-stage data port (dmemaddr, dmemwdata, dmemwrite, dmemread, dmemrdata) with a word-organised RAM and a small memory-mapped I/O page. The I/O page holds an output port, a synchronised input port, a timer with compare and sticky flag, and a RAM access counter. Reads are combinational so the core can capture dmemrdata into MEM/WB on the same edge. Writes commit on the rising clock edge.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS-lite MEM stage: word RAM plus a small I/O page
// (output port, synchronised input, timer/compare, status flags, RAM access counter).
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 7,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  input  logic [15:0] ioin,
  output logic [15:0] ioout,
  output logic        timer_irq,
  output logic        misalign
);

  localparam int DATA_W = 16;
  localparam int WORDS  = 1 << DEPTH_LOG2;

  localparam logic [7:0] OFF_OUT    = 8'h00;
  localparam logic [7:0] OFF_IN     = 8'h02;
  localparam logic [7:0] OFF_TIMER  = 8'h04;
  localparam logic [7:0] OFF_CMP    = 8'h06;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_ACCNT  = 8'h0A;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] v);
    return v + 1'b1;
  endfunction

  logic [DATA_W-1:0]     mem [WORDS];
  logic [DATA_W-1:0]     out_q;
  logic [DATA_W-1:0]     sync_p0;
  logic [DATA_W-1:0]     sync_p1;
  logic [DATA_W-1:0]     timer_q;
  logic [DATA_W-1:0]     cmp_q;
  logic [DATA_W-1:0]     accnt_q;
  logic                  tflag_q;
  logic                  mflag_q;

  logic                  io_hit;
  logic [7:0]            io_off;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  ram_access;
  logic                  ram_we;
  logic                  io_we;
  logic                  odd_access;
  logic                  status_we;
  logic [DATA_W-1:0]     rdata_sel;

  // Bit 0 is dropped everywhere: odd addresses hit the even word and only raise misalign.
  assign io_hit     = (dmemaddr[15:8] == IO_BASE[15:8]);
  assign io_off     = {dmemaddr[7:1], 1'b0};
  assign ram_idx    = dmemaddr[DEPTH_LOG2:1];
  assign ram_access = !io_hit && (dmemread || dmemwrite);
  assign ram_we     = !io_hit && dmemwrite && !reset;
  assign io_we      = io_hit && dmemwrite;
  assign odd_access = (dmemread || dmemwrite) && dmemaddr[0];
  assign status_we  = io_we && (io_off == OFF_STATUS);

  always_comb begin
    rdata_sel = '0;
    if (io_hit) begin
      case (io_off)
        OFF_OUT:    rdata_sel = out_q;
        OFF_IN:     rdata_sel = sync_p1;
        OFF_TIMER:  rdata_sel = timer_q;
        OFF_CMP:    rdata_sel = cmp_q;
        OFF_STATUS: rdata_sel = {{(DATA_W-2){1'b0}}, mflag_q, tflag_q};
        OFF_ACCNT:  rdata_sel = accnt_q;
        default:    rdata_sel = '0;
      endcase
    end else begin
      rdata_sel = mem[ram_idx];
    end
    dmemrdata = dmemread ? rdata_sel : '0;
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem[ram_idx] <= dmemwdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= '0;
      sync_p0 <= '0;
      sync_p1 <= '0;
      timer_q <= '0;
      cmp_q   <= '0;
      accnt_q <= '0;
      tflag_q <= 1'b0;
      mflag_q <= 1'b0;
    end else begin
      // ioin is asynchronous: two flop stages before it is readable
      sync_p0 <= ioin;
      sync_p1 <= sync_p0;

      if (io_we && (io_off == OFF_OUT)) begin
        out_q <= dmemwdata;
      end

      if (io_we && (io_off == OFF_TIMER)) begin
        timer_q <= dmemwdata;
      end else begin
        timer_q <= wrap_inc(timer_q);
      end

      if (io_we && (io_off == OFF_CMP)) begin
        cmp_q <= dmemwdata;
      end

      // Set beats write-1-to-clear; compare uses pre-update TIMER and CMP.
      tflag_q <= (timer_q == cmp_q) || (tflag_q && !(status_we && dmemwdata[0]));
      mflag_q <= odd_access || (mflag_q && !(status_we && dmemwdata[1]));

      if (io_we && (io_off == OFF_ACCNT)) begin
        accnt_q <= '0;
      end else if (ram_access) begin
        accnt_q <= sat_inc(accnt_q);
      end
    end
  end

  assign ioout     = out_q;
  assign timer_irq = tflag_q;
  assign misalign  = mflag_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: RAM, collision, timer, sync, flags, reset, ACCNT.
module tb_dmem_responder;

  localparam int DEPTH_LOG2 = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dmemaddr = '0;
  logic [15:0] dmemwdata = '0;
  logic        dmemwrite = 1'b0;
  logic        dmemread = 1'b0;
  logic [15:0] dmemrdata;
  logic [15:0] ioin = '0;
  logic [15:0] ioout;
  logic        timer_irq;
  logic        misalign;

  dmem_responder #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .IO_BASE   (16'hFF00)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .dmemaddr (dmemaddr),
    .dmemwdata(dmemwdata),
    .dmemwrite(dmemwrite),
    .dmemread (dmemread),
    .dmemrdata(dmemrdata),
    .ioin     (ioin),
    .ioout    (ioout),
    .timer_irq(timer_irq),
    .misalign (misalign)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] acc_model = '0;
  string       tag_q[$];
  logic [15:0] val_q[$];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dmemread  = 1'b0;
    dmemwrite = 1'b0;
    dmemaddr  = '0;
    dmemwdata = '0;
  endtask

  task automatic count_access(input logic [15:0] a);
    if (a[15:8] != 8'hFF && !reset && acc_model != 16'hFFFF) acc_model = acc_model + 16'd1;
  endtask

  task automatic expect_val(input string t, input logic [15:0] v);
    tag_q.push_back(t);
    val_q.push_back(v);
  endtask

  task automatic chk(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    checks++;
    if (val_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic chk_now(input string t, input logic [15:0] e, input logic [15:0] obs);
    expect_val(t, e);
    chk(obs);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    dmemaddr  = a;
    dmemwdata = d;
    dmemwrite = 1'b1;
    dmemread  = 1'b0;
    count_access(a);
    cyc();
    idle();
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string t);
    dmemaddr  = a;
    dmemread  = 1'b1;
    dmemwrite = 1'b0;
    expect_val(t, e);
    #1;
    chk(dmemrdata);
    count_access(a);
    cyc();
    idle();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    idle();
    cyc();
    cyc();
    chk_now("rst_ioout", 16'h0000, ioout);
    chk_now("rst_flags", 16'h0000, {14'b0, misalign, timer_irq});
    rd(16'hFF04, 16'h0000, "rst_timer");
    rd(16'hFF0A, 16'h0000, "rst_accnt");
    reset = 1'b0;
    acc_model = '0;
    cyc();
    chk_now("irq_after_release", 16'h0001, {15'b0, timer_irq});

    // RAM basics and aliasing
    wr(16'h0010, 16'hBEEF);
    rd(16'h0010, 16'hBEEF, "ram_rd");
    rd(16'h0010 + 16'(1 << (DEPTH_LOG2 + 1)), 16'hBEEF, "ram_alias");
    dmemaddr = 16'h0010;
    dmemread = 1'b0;
    expect_val("rd_disabled", 16'h0000);
    #1;
    chk(dmemrdata);
    cyc();
    idle();

    // Read/write collision returns old data
    wr(16'h0020, 16'h1111);
    rd(16'hFF0A, acc_model, "accnt_before_coll");
    dmemaddr  = 16'h0020;
    dmemwdata = 16'h2222;
    dmemwrite = 1'b1;
    dmemread  = 1'b1;
    expect_val("coll_old", 16'h1111);
    #1;
    chk(dmemrdata);
    count_access(16'h0020);
    cyc();
    idle();
    rd(16'h0020, 16'h2222, "coll_new");
    rd(16'hFF0A, acc_model, "accnt_after_coll");

    // Timer compare
    wr(16'hFF06, 16'h0005);
    wr(16'hFF04, 16'h0000);
    wr(16'hFF08, 16'h0003);
    chk_now("irq_cleared", 16'h0000, {15'b0, timer_irq});
    repeat (4) cyc();
    chk_now("irq_before_match", 16'h0000, {15'b0, timer_irq});
    rd(16'hFF04, 16'h0005, "timer_at_5");
    chk_now("irq_at_match", 16'h0001, {15'b0, timer_irq});
    wr(16'hFF08, 16'h0001);
    chk_now("irq_w1c", 16'h0000, {15'b0, timer_irq});
    wr(16'hFF04, 16'h0003);
    cyc();
    cyc();
    wr(16'hFF08, 16'h0001);
    chk_now("irq_set_wins", 16'h0001, {15'b0, timer_irq});
    wr(16'hFF08, 16'h0001);
    wr(16'hFF06, 16'h0007);
    chk_now("irq_cmp_old", 16'h0000, {15'b0, timer_irq});

    // Input synchroniser
    ioin = 16'hA5A5;
    cyc();
    rd(16'hFF02, 16'h0000, "sync_1edge");
    rd(16'hFF02, 16'hA5A5, "sync_2edge");

    // Misalign and unmapped offsets
    wr(16'hFF01, 16'h00FF);
    chk_now("out_odd", 16'h00FF, ioout);
    chk_now("misalign_set", 16'h0001, {15'b0, misalign});
    rd(16'hFF40, 16'h0000, "unmapped");
    wr(16'hFF08, 16'h0002);
    chk_now("misalign_clr", 16'h0000, {15'b0, misalign});
    rd(16'h0011, 16'hBEEF, "ram_odd_rd");
    chk_now("misalign_ram", 16'h0001, {15'b0, misalign});
    wr(16'hFF09, 16'h0002);
    chk_now("misalign_set_wins", 16'h0001, {15'b0, misalign});
    wr(16'hFF08, 16'h0002);

    // Reset mid-run with a write attempted in the reset cycle
    wr(16'h0030, 16'h7777);
    wr(16'hFF00, 16'h0005);
    chk_now("out_5", 16'h0005, ioout);
    rd(16'h0031, 16'h7777, "ram_odd_pre_rst");
    reset     = 1'b1;
    dmemaddr  = 16'h0031;
    dmemwdata = 16'hDEAD;
    dmemwrite = 1'b1;
    cyc();
    idle();
    acc_model = '0;
    chk_now("midrst_ioout", 16'h0000, ioout);
    chk_now("midrst_flags", 16'h0000, {14'b0, misalign, timer_irq});
    rd(16'hFF04, 16'h0000, "midrst_timer");
    rd(16'hFF0A, 16'h0000, "midrst_accnt");
    rd(16'h0030, 16'h7777, "midrst_ram_kept");
    reset = 1'b0;

    // ACCNT saturation and clear
    dmemaddr = 16'h0000;
    dmemread = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      count_access(16'h0000);
      cyc();
    end
    idle();
    rd(16'hFF0A, 16'hFFFF, "accnt_sat");
    wr(16'h0002, 16'h1234);
    rd(16'hFF0A, 16'hFFFF, "accnt_sat_hold");
    wr(16'hFF0A, 16'h1234);
    acc_model = '0;
    rd(16'hFF0A, 16'h0000, "accnt_clear");
    rd(16'h0002, 16'h1234, "ram_after_sat");
    rd(16'hFF0A, acc_model, "accnt_recount");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
